// File: rtl/register_scoreboard.sv
// Pending-write scoreboard for the register file: stalls decode on pending sources or a saturated destination count.
// Hazards use registered counts only, so a writeback clears its hazard one cycle after it occurs.
module register_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int CNT_W    = 2,
   parameter int PERF_W   = 16
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Issue_valid,
   input  logic                Issue_writes,
   input  logic [ADDR_W-1:0]   Issue_dest,
   input  logic                Src_used_1,
   input  logic [ADDR_W-1:0]   Src_register_1,
   input  logic                Src_used_2,
   input  logic [ADDR_W-1:0]   Src_register_2,
   input  logic                Wb_valid,
   input  logic [ADDR_W-1:0]   Wb_register,
   output logic                Stall,
   output logic                Issue_accept,
   output logic [NUM_REGS-1:0] Busy_vector,
   output logic                Underflow_error,
   output logic [PERF_W-1:0]   Stall_count
);

   localparam logic [CNT_W-1:0] MAX = '1;

   logic [CNT_W-1:0] cnt [NUM_REGS];
   logic h1, h2, hf;
   logic inc_en, dec_en, under;

   always_comb begin
      h1           = Src_used_1 && (Src_register_1 != '0) && (cnt[Src_register_1] != '0);
      h2           = Src_used_2 && (Src_register_2 != '0) && (cnt[Src_register_2] != '0);
      hf           = Issue_writes && (Issue_dest != '0) && (cnt[Issue_dest] == MAX);
      Stall        = Issue_valid && (h1 || h2 || hf);
      Issue_accept = Issue_valid && !Stall;
      inc_en       = Issue_accept && Issue_writes && (Issue_dest != '0);
      dec_en       = Wb_valid && (Wb_register != '0) && (cnt[Wb_register] != '0);
      under        = Wb_valid && (Wb_register != '0) && (cnt[Wb_register] == '0);
   end

   genvar g;
   generate
      for (g = 0; g < NUM_REGS; g++) begin : g_busy
         assign Busy_vector[g] = (cnt[g] != '0);
      end
   endgenerate

   // Register 0 is never written after reset, so it can never report busy.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt[r] <= '0;
         end
         Underflow_error <= 1'b0;
         Stall_count     <= '0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (inc_en && (Issue_dest == ADDR_W'(r)) &&
                !(dec_en && (Wb_register == ADDR_W'(r)))) begin
               cnt[r] <= cnt[r] + CNT_W'(1);
            end else if (dec_en && (Wb_register == ADDR_W'(r)) &&
                         !(inc_en && (Issue_dest == ADDR_W'(r)))) begin
               cnt[r] <= cnt[r] - CNT_W'(1);
            end
         end
         if (under) begin
            Underflow_error <= 1'b1;
         end
         if (Stall && (Stall_count != '1)) begin
            Stall_count <= Stall_count + PERF_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_register_scoreboard.sv
// Bench for register_scoreboard: directed table, corner-case sequences and random traffic against an integer-count model.
module tb_register_scoreboard;

   localparam int NR = 32;
   localparam int AW = 5;
   localparam int CW = 2;
   localparam int PW = 16;
   localparam int MAXC = 3;
   localparam int SAT = 65535;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          Issue_valid, Issue_writes, Src_used_1, Src_used_2, Wb_valid;
   logic [AW-1:0] Issue_dest, Src_register_1, Src_register_2, Wb_register;
   logic          Stall, Issue_accept, Underflow_error;
   logic [NR-1:0] Busy_vector;
   logic [PW-1:0] Stall_count;

   always #5 Clock = ~Clock;

   register_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .CNT_W(CW), .PERF_W(PW)) dut (
      .Clock(Clock), .Reset(Reset),
      .Issue_valid(Issue_valid), .Issue_writes(Issue_writes), .Issue_dest(Issue_dest),
      .Src_used_1(Src_used_1), .Src_register_1(Src_register_1),
      .Src_used_2(Src_used_2), .Src_register_2(Src_register_2),
      .Wb_valid(Wb_valid), .Wb_register(Wb_register),
      .Stall(Stall), .Issue_accept(Issue_accept), .Busy_vector(Busy_vector),
      .Underflow_error(Underflow_error), .Stall_count(Stall_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: plain integer pending-write counts per register.
   int m_cnt [NR];
   bit m_uf;
   int m_sc;

   typedef struct {
      logic          iv, wr;
      logic [AW-1:0] dst;
      logic          u1;
      logic [AW-1:0] s1;
      logic          u2;
      logic [AW-1:0] s2;
      logic          wv;
      logic [AW-1:0] wreg;
      logic          exp_stall;
      logic [NR-1:0] exp_busy;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic m_reset();
      for (int r = 0; r < NR; r++) m_cnt[r] = 0;
      m_uf = 0;
      m_sc = 0;
   endtask

   function automatic bit m_stall();
      bit haz;
      haz = 0;
      if (Src_used_1 && Src_register_1 != 0 && m_cnt[Src_register_1] > 0) haz = 1;
      if (Src_used_2 && Src_register_2 != 0 && m_cnt[Src_register_2] > 0) haz = 1;
      if (Issue_writes && Issue_dest != 0 && m_cnt[Issue_dest] == MAXC) haz = 1;
      return Issue_valid && haz;
   endfunction

   function automatic logic [NR-1:0] m_busy();
      logic [NR-1:0] b;
      for (int r = 0; r < NR; r++) b[r] = (m_cnt[r] > 0);
      return b;
   endfunction

   task automatic m_update();
      bit st, do_inc, do_dec;
      st     = m_stall();
      do_inc = Issue_valid && !st && Issue_writes && Issue_dest != 0;
      do_dec = 0;
      if (Wb_valid && Wb_register != 0) begin
         if (m_cnt[Wb_register] == 0) m_uf = 1;
         else do_dec = 1;
      end
      if (do_inc) m_cnt[Issue_dest] = m_cnt[Issue_dest] + 1;
      if (do_dec) m_cnt[Wb_register] = m_cnt[Wb_register] - 1;
      if (st && m_sc < SAT) m_sc = m_sc + 1;
   endtask

   task automatic drive(input logic iv, input logic wr, input int dst,
                        input logic u1, input int s1, input logic u2, input int s2,
                        input logic wv, input int wreg);
      Issue_valid    = iv;
      Issue_writes   = wr;
      Issue_dest     = AW'(dst);
      Src_used_1     = u1;
      Src_register_1 = AW'(s1);
      Src_used_2     = u2;
      Src_register_2 = AW'(s2);
      Wb_valid       = wv;
      Wb_register    = AW'(wreg);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Called at a negedge with inputs already driven; compares, then advances one cycle.
   task automatic step();
      #1;
      chk("stall", 32'(Stall), 32'(m_stall()));
      chk("accept", 32'(Issue_accept), 32'(Issue_valid && !m_stall()));
      chk("busy", Busy_vector, m_busy());
      chk("underflow", 32'(Underflow_error), 32'(m_uf));
      chk("stall_count", 32'(Stall_count), 32'(m_sc));
      @(posedge Clock);
      m_update();
      @(negedge Clock);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      idle();
      m_reset();
      #1;
      chk("reset_busy", Busy_vector, '0);
      chk("reset_uf", 32'(Underflow_error), 32'd0);
      chk("reset_sc", 32'(Stall_count), 32'd0);
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
   endtask

   initial begin
      //          iv wr dst u1 s1 u2 s2 wv wreg stall busy
      tbl[0] = '{1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 32'h0};
      tbl[1] = '{1, 1, 6, 1, 5, 0, 0, 0, 0, 1, 32'h20};
      tbl[2] = '{1, 1, 6, 1, 5, 0, 0, 1, 5, 1, 32'h20};
      tbl[3] = '{1, 1, 6, 1, 5, 0, 0, 0, 0, 0, 32'h0};
      tbl[4] = '{1, 1, 0, 1, 0, 1, 6, 1, 0, 1, 32'h40};
      tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 32'h40};
      tbl[6] = '{1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 32'h0};
      tbl[7] = '{0, 1, 5, 1, 5, 0, 0, 0, 0, 0, 32'h0};
      tbl[8] = '{1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 32'h0};
      tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20};

      @(negedge Clock);
      do_reset();

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].iv, tbl[i].wr, int'(tbl[i].dst), tbl[i].u1, int'(tbl[i].s1),
               tbl[i].u2, int'(tbl[i].s2), tbl[i].wv, int'(tbl[i].wreg));
         #1;
         chk($sformatf("tbl%0d_stall", i), 32'(Stall), 32'(tbl[i].exp_stall));
         chk($sformatf("tbl%0d_busy", i), Busy_vector, tbl[i].exp_busy);
         step();
      end

      // Saturated destination: three in flight to r7, the fourth waits for a writeback.
      drive(0, 0, 0, 0, 0, 0, 0, 1, 5); step();
      for (int k = 0; k < 3; k++) begin
         drive(1, 1, 7, 0, 0, 0, 0, 0, 0); step();
      end
      drive(1, 1, 7, 0, 0, 0, 0, 0, 0);
      #1 chk("full_stall", 32'(Stall), 32'd1);
      step();
      drive(1, 1, 7, 0, 0, 0, 0, 1, 7);
      #1 chk("full_stall_wb_same_cycle", 32'(Stall), 32'd1);
      step();
      drive(1, 1, 7, 0, 0, 0, 0, 0, 0);
      #1 chk("full_accept_after_wb", 32'(Issue_accept), 32'd1);
      step();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 7); step();
      end
      chk("r7_drained", 32'(Busy_vector[7]), 32'd0);

      // Same-cycle issue and writeback on r9 leaves its count at one.
      drive(1, 1, 9, 0, 0, 0, 0, 0, 0); step();
      drive(1, 1, 9, 0, 0, 0, 0, 1, 9); step();
      chk("r9_still_busy", 32'(Busy_vector[9]), 32'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 9); step();
      chk("r9_single_wb_clears", 32'(Busy_vector[9]), 32'd0);

      // Register 0 is ignored; a writeback to idle r3 sets the sticky error.
      drive(1, 1, 0, 1, 0, 1, 0, 1, 0);
      #1 chk("r0_no_stall", 32'(Stall), 32'd0);
      step();
      chk("r0_no_error", 32'(Underflow_error), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 3); step();
      chk("underflow_set", 32'(Underflow_error), 32'd1);
      idle(); repeat (3) step();
      chk("underflow_sticky", 32'(Underflow_error), 32'd1);

      // Random traffic on a small register window to make hazards common.
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
               1'($urandom_range(0, 1)), $urandom_range(0, 7),
               1'($urandom_range(0, 1)), $urandom_range(0, 7),
               1'($urandom_range(0, 1)), $urandom_range(0, 7));
         step();
      end

      // Asynchronous reset in the middle of a cycle with r5 at count two.
      do_reset();
      drive(1, 1, 5, 0, 0, 0, 0, 0, 0); step(); step();
      drive(1, 0, 0, 1, 5, 0, 0, 0, 0); step(); step();
      chk("pre_reset_sc", 32'(Stall_count), 32'd2);
      #2 Reset = 1'b1;
      m_reset();
      #1;
      chk("mid_reset_busy", Busy_vector, '0);
      chk("mid_reset_stall", 32'(Stall), 32'd0);
      chk("mid_reset_accept", 32'(Issue_accept), 32'd1);
      chk("mid_reset_sc", 32'(Stall_count), 32'd0);
      @(negedge Clock);
      Reset = 1'b0;
      idle(); step();

      // Stall counter saturation over a long held hazard.
      drive(1, 1, 5, 0, 0, 0, 0, 0, 0); step();
      drive(1, 0, 0, 1, 5, 0, 0, 0, 0);
      repeat (SAT + 4) begin
         @(posedge Clock);
         m_update();
      end
      @(negedge Clock);
      chk("sc_saturated", 32'(Stall_count), 32'h0000FFFF);
      chk("sc_model", 32'(Stall_count), 32'(m_sc));
      step();
      chk("sc_no_wrap", 32'(Stall_count), 32'h0000FFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
